// File: rtl/alu_pkg.sv
// alu_pkg: op-codes and width shared by the ALU, its interface and its shifter
package alu_pkg;
    localparam int DATA_W = 32;
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_COMP = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;
    localparam logic [3:0] ALU_SHLL = 4'h4;
    localparam logic [3:0] ALU_SHRL = 4'h5;
    localparam logic [3:0] ALU_SHRA = 4'h6;
    localparam logic [3:0] ALU_MUL  = 4'h7;
    localparam logic [3:0] ALU_SUB  = 4'h8;
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/control inputs and registered result/flag outputs of the ALU
interface alu_if;
    import alu_pkg::*;
    logic [DATA_W-1:0] operand0;
    logic [DATA_W-1:0] operand1;
    logic [3:0]        control;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] result1;
    logic              zFlag;
    logic              carryFlag;
    logic              signFlag;
    logic              overflowFlag;
    modport master(output operand0, operand1, control,
                   input result, result1, zFlag, carryFlag, signFlag, overflowFlag);
    modport slave(input operand0, operand1, control,
                  output result, result1, zFlag, carryFlag, signFlag, overflowFlag);
endinterface

// File: rtl/alu_shifter.sv
// alu_shifter: barrel shifter for SHLL/SHRL/SHRA with the last shifted-out bit as carry
module alu_shifter
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [4:0]        sh,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] res,
    output logic              carry
);
    logic [DATA_W:0]        l;
    logic [DATA_W:0]        rl;
    logic signed [DATA_W:0] ra;
    // A guard bit beside the word catches the last bit shifted out; it stays 0 for sh = 0
    assign l  = {1'b0, data} << sh;
    assign rl = {data, 1'b0} >> sh;
    assign ra = $signed({data, 1'b0}) >>> sh;
    always_comb begin
        res   = op == ALU_SHLL ? l[DATA_W-1:0] : op == ALU_SHRL ? rl[DATA_W:1] : ra[DATA_W:1];
        carry = op == ALU_SHLL ? l[DATA_W] : op == ALU_SHRL ? rl[0] : ra[0];
    end
endmodule

// File: rtl/alu.sv
// alu: one-cycle registered 32-bit ALU with multiply high word and branch flags
module alu
    import alu_pkg::*;
(
    input logic  clk,
    input logic  rst_n,
    alu_if.slave bus
);
    logic [DATA_W-1:0]          op0, op1, add_a, add_b, sh_res;
    logic [DATA_W-1:0]          result_d, result_q, result1_d, result1_q;
    logic [DATA_W:0]            sum;
    logic signed [2*DATA_W-1:0] prod;
    logic neg_b, add_v, sh_c;
    logic carry_d, carry_q, ovf_d, ovf_q, z_d, z_q, s_d, s_q;
    assign op0 = bus.operand0;
    assign op1 = bus.operand1;
    // One adder: SUB is op0 + ~op1 + 1, COMP is 0 + ~op1 + 1
    assign neg_b = bus.control == ALU_SUB || bus.control == ALU_COMP;
    assign add_a = bus.control == ALU_COMP ? '0 : op0;
    assign add_b = neg_b ? ~op1 : op1;
    assign sum   = {1'b0, add_a} + {1'b0, add_b} + {{DATA_W{1'b0}}, neg_b};
    assign add_v = add_a[DATA_W-1] == add_b[DATA_W-1] && sum[DATA_W-1] != add_a[DATA_W-1];
    assign prod  = (2*DATA_W)'($signed(op0)) * (2*DATA_W)'($signed(op1));
    alu_shifter u_shifter (
        .data  (op0),
        .sh    (op1[4:0]),
        .op    (bus.control),
        .res   (sh_res),
        .carry (sh_c)
    );
    always_comb begin
        result_d  = '0;
        result1_d = '0;
        carry_d   = 1'b0;
        ovf_d     = 1'b0;
        case (bus.control)
            ALU_ADD, ALU_SUB: begin
                result_d = sum[DATA_W-1:0];
                carry_d  = sum[DATA_W];
                ovf_d    = add_v;
            end
            ALU_COMP: result_d = sum[DATA_W-1:0];
            ALU_AND:  result_d = op0 & op1;
            ALU_XOR:  result_d = op0 ^ op1;
            ALU_SHLL, ALU_SHRL, ALU_SHRA: begin
                result_d = sh_res;
                carry_d  = sh_c;
            end
            ALU_MUL:  {result1_d, result_d} = prod;
            default:  ;
        endcase
        z_d = result_d == '0;
        s_d = result_d[DATA_W-1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            result1_q <= '0;
            z_q       <= 1'b0;
            carry_q   <= 1'b0;
            s_q       <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            result_q  <= result_d;
            result1_q <= result1_d;
            z_q       <= z_d;
            carry_q   <= carry_d;
            s_q       <= s_d;
            ovf_q     <= ovf_d;
        end
    end
    assign bus.result       = result_q;
    assign bus.result1      = result1_q;
    assign bus.zFlag        = z_q;
    assign bus.carryFlag    = carry_q;
    assign bus.signFlag     = s_q;
    assign bus.overflowFlag = ovf_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu; expectations are {result, result1, z, c, s, v}
module tb_alu;
    import alu_pkg::*;
    typedef struct packed {
        logic [31:0] r;
        logic [31:0] r1;
        logic        z, c, s, v;
    } exp_t;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        exp_t        e;
    } vec_t;
    localparam logic [31:0] A = 32'h00040600;
    localparam logic [31:0] B = 32'hFFFFFFE9;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    alu_if bus();
    alu dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic exp_t obs();
        return {bus.result, bus.result1, bus.zFlag, bus.carryFlag, bus.signFlag, bus.overflowFlag};
    endfunction
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl);
        exp_t   e = '0;
        int     sh = int'(b[4:0]);
        longint t;
        longint u;
        case (ctl)
            4'h0: begin
                e.r = a + b;
                u = longint'({32'b0, a}) + longint'({32'b0, b});
                e.c = u > 64'hFFFFFFFF;
                t = longint'($signed(a)) + longint'($signed(b));
                e.v = t != longint'(int'(t));
            end
            4'h8: begin
                e.r = a - b;
                e.c = a >= b;
                t = longint'($signed(a)) - longint'($signed(b));
                e.v = t != longint'(int'(t));
            end
            4'h1: e.r = -b;
            4'h2: e.r = a & b;
            4'h3: e.r = a ^ b;
            4'h4: begin e.r = a << sh; e.c = sh != 0 ? a[32-sh] : 1'b0; end
            4'h5: begin e.r = a >> sh; e.c = sh != 0 ? a[sh-1] : 1'b0; end
            4'h6: begin e.r = 32'($signed(a) >>> sh); e.c = sh != 0 ? a[sh-1] : 1'b0; end
            4'h7: begin t = longint'($signed(a)) * longint'($signed(b)); {e.r1, e.r} = t; end
            default: ;
        endcase
        e.z = e.r == 32'h0;
        e.s = e.r[31];
        return e;
    endfunction
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl, input exp_t e);
        bus.operand0 = a;
        bus.operand1 = b;
        bus.control  = ctl;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        bus.operand0 = 32'h7FFFFFFF;
        bus.operand1 = 32'h1;
        bus.control  = ALU_ADD;
        #1 rst_n = 1'b0;
        #1 checks++;
        if (obs() !== '0) begin errors++; $display("FAIL reset_async: got %h want 0", obs()); end
        @(posedge clk);
        #1 checks++;
        if (obs() !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", obs()); end
        @(negedge clk) rst_n = 1'b1;
    endtask
    task automatic test_add_sub();
        vec_t v[4] = '{
            '{A, B, ALU_ADD,  {32'h000405E9, 32'h0, 4'b0100}},
            '{A, B, ALU_SUB,  {32'h00040617, 32'h0, 4'b0000}},
            '{A, B, ALU_COMP, {32'h00000017, 32'h0, 4'b0000}},
            '{32'h0, 32'h0, ALU_COMP, {32'h00000000, 32'h0, 4'b1000}}
        };
        foreach (v[i]) begin
            exp_t e;
            issue(v[i].a, v[i].b, v[i].ctl, v[i].e);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL add_sub[%0d]: got %h want %h", i, obs(), e); end
        end
    endtask
    task automatic test_logic_shift();
        vec_t v[6] = '{
            '{A, B, ALU_AND, {32'h00040600, 32'h0, 4'b0000}},
            '{A, B, ALU_XOR, {32'hFFFBF9E9, 32'h0, 4'b0010}},
            '{A, 32'hFFFFFFE9 & 32'h9 | 32'hFFFFFFE0 | 32'h9, ALU_SHLL, {32'h080C0000, 32'h0, 4'b0000}},
            '{A, 32'h9, ALU_SHRL, {32'h00000203, 32'h0, 4'b0000}},
            '{32'h80000000, 32'h4, ALU_SHRA, {32'hF8000000, 32'h0, 4'b0010}},
            '{32'h80000001, 32'h1, ALU_SHRL, {32'h40000000, 32'h0, 4'b0100}}
        };
        foreach (v[i]) begin
            exp_t e;
            issue(v[i].a, v[i].b, v[i].ctl, v[i].e);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL logic_shift[%0d]: got %h want %h", i, obs(), e); end
        end
    endtask
    task automatic test_mul_boundary();
        vec_t v[5] = '{
            '{A, B, ALU_MUL, {32'hFFA37600, 32'hFFFFFFFF, 4'b0010}},
            '{A, B, ALU_ADD, {32'h000405E9, 32'h0, 4'b0100}},
            '{32'h7FFFFFFF, 32'h1, ALU_ADD, {32'h80000000, 32'h0, 4'b0011}},
            '{32'h12345678, 32'h12345678, ALU_SUB, {32'h00000000, 32'h0, 4'b1100}},
            '{A, B, 4'hF, {32'h00000000, 32'h0, 4'b1000}}
        };
        foreach (v[i]) begin
            exp_t e;
            issue(v[i].a, v[i].b, v[i].ctl, v[i].e);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL mul_boundary[%0d]: got %h want %h", i, obs(), e); end
        end
    endtask
    task automatic test_midstream_reset();
        exp_t e;
        issue(A, B, ALU_MUL, model(A, B, ALU_MUL));
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL mid_reset_pre: got %h want %h", obs(), e); end
        bus.operand0 = 32'hFFFFFFFF;
        bus.operand1 = 32'h1;
        bus.control  = ALU_SUB;
        q.push_back(model(32'hFFFFFFFF, 32'h1, ALU_SUB));
        #2 rst_n = 1'b0;
        #1 checks++;
        if (obs() !== '0) begin errors++; $display("FAIL mid_reset_async: got %h want 0", obs()); end
        @(posedge clk);
        #1 checks++;
        if (obs() !== '0) begin errors++; $display("FAIL mid_reset_hold: got %h want 0", obs()); end
        q.delete();
        @(negedge clk) rst_n = 1'b1;
        issue(A, 32'h9, ALU_SHLL, model(A, 32'h9, ALU_SHLL));
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL mid_reset_post: got %h want %h", obs(), e); end
    endtask
    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a = $urandom;
            logic [31:0] b = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            logic [3:0]  ctl = (i < 36) ? 4'(i % 9) : 4'($urandom_range(0, 15));
            exp_t e;
            if (i % 7 == 0) b = a;
            issue(a, b, ctl, model(a, b, ctl));
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] ctl=%h a=%h b=%h: got %h want %h", i, ctl, a, b, obs(), e);
            end
        end
    endtask
    initial begin
        test_reset();
        test_add_sub();
        test_logic_shift();
        test_mul_boundary();
        test_midstream_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
